cpu_ifetch_queue: RTL and testbench

//  Parametrised successor to the single-entry instruction fetch unit. Keeps up to MAX_OUTSTANDING

---
 rtl/cpu_pkg.sv | 14 +
 rtl/cpu_ifq_fifo.sv | 72 +++++++
 rtl/cpu_ifetch_queue.sv | 139 +++++++++++++
 tb/tb_cpu_ifetch_queue.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU fetch path.
package cpu_pkg;

  localparam logic [31:0] CPU_RESET_ADDR = 32'hFFFF0000;

  // One prefetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  localparam int IFQ_ENTRY_W = $bits(ifq_entry_t);

endpackage

// File: rtl/cpu_ifq_fifo.sv
// Generic DEPTH-entry FIFO of ifq_entry_t with push/pop/clear.
// The head is read combinationally from storage; clear overrides push and pop.
module cpu_ifq_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [IFQ_ENTRY_W-1:0]     wdata,
  input  logic                       pop,
  input  logic                       clear,
  output logic [$clog2(DEPTH):0]     count,
  output logic [IFQ_ENTRY_W-1:0]     head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  ifq_entry_t    mem_q [DEPTH];
  ifq_entry_t    mem_d [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are AW bits wide, so DEPTH being a power of two gives free wrap.
      if (push) begin
        mem_d[wr_ptr_q] = ifq_entry_t'(wdata);
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // The fetch credit rule keeps acks away from a full queue.
  always_ff @(posedge clk) begin
    if (!reset && push && !clear)
      assert (count_q != CW'(DEPTH));
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cpu_ifetch_queue.sv
// Pipelined instruction fetch: keeps up to MAX_OUTSTANDING cpui reads in flight and
// buffers returned words for decode. Optional counters under CPU_IFQ_PERF_EN.
module cpu_ifetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_ADDR      = CPU_RESET_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  output logic        cpui_request,
  output logic [31:0] cpui_addr,
  input  logic [31:0] cpui_rdata,
  input  logic        cpui_ack,
  output logic [31:0] p2_instr,
  output logic [31:0] p2_pc,
  output logic        p2_instr_valid,
  input  logic        p2_bubble,
  input  logic        p3_jump_taken,
  input  logic [31:0] p3_jump_addr
`ifdef CPU_IFQ_PERF_EN
  ,
  output logic [31:0] perf_starve,
  output logic [31:0] perf_flush
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;

  logic          flush, pop, ack_live, issue, credit_ok;
  logic [CW-1:0] count;
  ifq_entry_t    head;
  logic [31:0]   target_pc;

  assign flush     = p3_jump_taken && !stall;
  assign pop       = p2_instr_valid && !stall && !p2_bubble;
  assign target_pc = p3_jump_addr & ~32'h3;
  // An ack landing on the flush edge belongs to the old stream and is dropped.
  assign ack_live  = cpui_ack && (discard_q == '0) && !flush;

  // Live requests plus queued words must fit the queue so every ack has a slot.
  assign credit_ok = (int'(count) + int'(outstanding_q) - int'(discard_q)) < DEPTH;
  assign issue     = !flush && (int'(outstanding_q) < MAX_OUTSTANDING) && credit_ok;

  always_comb begin
    req_d         = issue;
    addr_d        = addr_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + OW'(issue) - OW'(cpui_ack);
    discard_d     = discard_q;

    if (issue) begin
      addr_d     = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (flush) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      // Everything still in flight after this edge is stale.
      discard_d  = outstanding_q - OW'(cpui_ack);
    end else begin
      if (cpui_ack && discard_q != '0) discard_d = discard_q - 1'b1;
      if (ack_live) resp_pc_d = resp_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q         <= 1'b0;
      addr_q        <= RESET_ADDR;
      fetch_pc_q    <= RESET_ADDR;
      resp_pc_q     <= RESET_ADDR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      req_q         <= req_d;
      addr_q        <= addr_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  cpu_ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .reset (reset),
    .push  (ack_live),
    .wdata ({resp_pc_q, cpui_rdata}),
    .pop   (pop),
    .clear (flush),
    .count (count),
    .head  (head)
  );

  assign cpui_request   = req_q;
  assign cpui_addr      = addr_q;
  assign p2_instr       = head.instr;
  assign p2_pc          = head.pc;
  assign p2_instr_valid = (count != '0);

`ifdef CPU_IFQ_PERF_EN
  logic [31:0] perf_starve_q, perf_starve_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_starve_d = perf_starve_q + 32'(!p2_instr_valid && !stall);
    perf_flush_d  = perf_flush_q + 32'(flush);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_starve_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      perf_starve_q <= perf_starve_d;
      perf_flush_q  <= perf_flush_d;
    end
  end

  assign perf_starve = perf_starve_q;
  assign perf_flush  = perf_flush_q;
`endif

endmodule

// File: tb/tb_cpu_ifetch_queue.sv
// Randomized scoreboard bench for cpu_ifetch_queue with an in-order bus responder model.
module tb_cpu_ifetch_queue;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RA    = 32'hFFFF0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        cpui_request;
  logic [31:0] cpui_addr;
  logic [31:0] cpui_rdata = '0;
  logic        cpui_ack = 1'b0;
  logic [31:0] p2_instr;
  logic [31:0] p2_pc;
  logic        p2_instr_valid;
  logic        p2_bubble = 1'b0;
  logic        p3_jump_taken = 1'b0;
  logic [31:0] p3_jump_addr = '0;
`ifdef CPU_IFQ_PERF_EN
  logic [31:0] perf_starve;
  logic [31:0] perf_flush;
`endif

  cpu_ifetch_queue #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_ADDR      (RA)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .cpui_request   (cpui_request),
    .cpui_addr      (cpui_addr),
    .cpui_rdata     (cpui_rdata),
    .cpui_ack       (cpui_ack),
    .p2_instr       (p2_instr),
    .p2_pc          (p2_pc),
    .p2_instr_valid (p2_instr_valid),
    .p2_bubble      (p2_bubble),
    .p3_jump_taken  (p3_jump_taken),
    .p3_jump_addr   (p3_jump_addr)
`ifdef CPU_IFQ_PERF_EN
    ,
    .perf_starve    (perf_starve),
    .perf_flush     (perf_flush)
`endif
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // ---------------- bus responder ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t pend[$];
  int    cyc    = 0;
  int    lat_lo = 1;
  int    lat_hi = 1;

  task automatic tick();
    pend_t p;
    @(posedge clock);
    #1;
    cyc++;
    cpui_ack = 1'b0;
    if (reset) begin
      pend.delete();
    end else begin
      if (cpui_request) begin
        p.addr = cpui_addr;
        p.due  = cyc + $urandom_range(lat_hi, lat_lo) - 1;
        pend.push_back(p);
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        cpui_ack   = 1'b1;
        cpui_rdata = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end
    end
  endtask

  // ---------------- reference model / monitor ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] exp_next = RA;
  logic [31:0] req_pc   = RA;
  int          pops     = 0;
  bit          started  = 0;
`ifdef CPU_IFQ_PERF_EN
  logic [31:0] starve_m = '0;
  logic [31:0] flush_m  = '0;
`endif

  initial begin
    ent_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        exp_next = RA;
        req_pc   = RA;
        started  = 1;
`ifdef CPU_IFQ_PERF_EN
        starve_m = '0;
        flush_m  = '0;
`endif
      end else if (started) begin
        // Fetch addresses follow the sequential stream, restarting at each accepted jump.
        if (cpui_request) begin
          chk("req_addr", cpui_addr, req_pc);
          req_pc = req_pc + 32'd4;
        end
        if (exp_q.size() == 0) begin
          e.pc    = exp_next;
          e.instr = mem_word(exp_next);
          exp_q.push_back(e);
          exp_next = exp_next + 32'd4;
        end
`ifdef CPU_IFQ_PERF_EN
        chk("perf_starve", perf_starve, starve_m);
        chk("perf_flush", perf_flush, flush_m);
        if (!p2_instr_valid && !stall) starve_m = starve_m + 32'd1;
`endif
        if (p2_instr_valid) begin
          chk("head_pc", p2_pc, exp_q[0].pc);
          chk("head_instr", p2_instr, exp_q[0].instr);
          if (!stall && !p2_bubble) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
        if (p3_jump_taken && !stall) begin
          exp_q.delete();
          exp_next = p3_jump_addr & ~32'h3;
          req_pc   = exp_next;
`ifdef CPU_IFQ_PERF_EN
          flush_m = flush_m + 32'd1;
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int p0;

    // Reset state and first-fetch latency on a zero-wait bus.
    reset = 1'b1;
    tick();
    tick();
    chk("rst_request", cpui_request, 0);
    chk("rst_addr", cpui_addr, RA);
    chk("rst_valid", p2_instr_valid, 0);
    reset = 1'b0;
    tick();
    chk("first_request", cpui_request, 1);
    chk("first_req_addr", cpui_addr, RA);
    chk("first_valid_early", p2_instr_valid, 0);
    tick();
    chk("first_valid", p2_instr_valid, 1);
    chk("first_pc", p2_pc, RA);
    p0 = pops;
    repeat (20) tick();
    chk("sustained_rate", (pops - p0 >= 18), 1);

    // Long stall: queue fills to DEPTH and fetch goes quiet.
    stall = 1'b1;
    repeat (10) tick();
    chk("stall_request", cpui_request, 0);
    chk("stall_inflight", pend.size(), 0);
    chk("stall_valid", p2_instr_valid, 1);
    lat_lo = 60;
    lat_hi = 60;
    stall  = 1'b0;
    p0     = pops;
    repeat (6) tick();
    chk("stall_drain_cnt", pops - p0, DEPTH);
    chk("stall_drained", p2_instr_valid, 0);
    lat_lo = 1;
    lat_hi = 1;
    repeat (70) tick();

    // Flush with two requests in flight: stale acks must be dropped.
    lat_lo = 3;
    lat_hi = 3;
    n = 0;
    while (pend.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("two_inflight_timeout", (n < 20), 1);
    p3_jump_taken = 1'b1;
    p3_jump_addr  = 32'h100;
    tick();
    p3_jump_taken = 1'b0;
    chk("flush_valid_low", p2_instr_valid, 0);
    n = 0;
    while (!p2_instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk("flush_refill_timeout", (n < 20), 1);
    chk("flush_head_pc", p2_pc, 32'h100);
    chk("flush_head_instr", p2_instr, mem_word(32'h100));
    repeat (10) tick();

    // Jump while stalled is ignored.
    lat_lo = 1;
    lat_hi = 1;
    repeat (10) tick();
    stall         = 1'b1;
    p3_jump_taken = 1'b1;
    p3_jump_addr  = 32'h200;
    repeat (2) tick();
    chk("stalljump_valid", p2_instr_valid, 1);
    p3_jump_taken = 1'b0;
    stall         = 1'b0;
    repeat (10) tick();

    // Decode bubble holds the head stable for three cycles.
    n = 0;
    while (!p2_instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bubble_setup_timeout", (n < 20), 1);
    p2_bubble = 1'b1;
    p0 = pops;
    repeat (3) tick();
    chk("bubble_no_pop", pops - p0, 0);
    p2_bubble = 1'b0;
    repeat (10) tick();

    // Randomized traffic: latency, stalls, bubbles, jumps (incl. unaligned) and resets.
    lat_lo = 1;
    lat_hi = 4;
    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399, 0) == 0) begin
        reset         = 1'b1;
        stall         = 1'b0;
        p2_bubble     = 1'b0;
        p3_jump_taken = 1'b0;
        tick();
        tick();
        reset = 1'b0;
      end
      stall         = ($urandom_range(4, 0) == 0);
      p2_bubble     = ($urandom_range(4, 0) == 0);
      p3_jump_taken = ($urandom_range(29, 0) == 0);
      p3_jump_addr  = $urandom;
      tick();
    end
    stall         = 1'b0;
    p2_bubble     = 1'b0;
    p3_jump_taken = 1'b0;
    repeat (20) tick();
    chk("random_liveness", (pops - p0 > 300), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
